instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Writer side of the instruction memory: fills the word-addressed instruction store that the fetch stage later reads by `program_counter` index.
- Accepts a byte stream from a host or boot source over a valid/ready handshake.
- Assembles each group of 4 bytes, MSB first, into a 32-bit instruction.
- Issues one write per word at consecutive word addresses starting at 0, then reports completion.

Parameters:
- ADDRESS_WIDTH, 32, width of `mem_write_address`. Word index, not byte address.
- MAX_WORDS, 64, capacity of the target instruction memory in words.
- COUNT_WIDTH, 8, width of `instruction_count`. Must hold MAX_WORDS.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  one-cycle request to begin a load. Sampled only in IDLE or DONE.
- instruction_count  input  COUNT_WIDTH  number of words to load. Sampled with `start`.
- byte_data  input  8  incoming program byte.
- byte_valid  input  1  `byte_data` is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_write_enable  output  1  one-cycle write strobe to instruction memory.
- mem_write_address  output  ADDRESS_WIDTH  word index being written.
- mem_write_data  output  32  assembled instruction.
- busy  output  1  high in RECEIVE or WRITE.
- load_done  output  1  high in DONE.
- load_error  output  1  the last start was rejected because `instruction_count` > MAX_WORDS.

Behaviour:
- Reset values: all outputs 0; state IDLE; word index 0; byte index 0; shift register 0.
- Reset mid-load discards any partial word and aborts the load; words already written stay in memory.
- States: IDLE, RECEIVE, WRITE, DONE.
- IDLE or DONE, on `start`:
  - Latch `instruction_count`.
  - Clear word index, byte index, `load_done` and `load_error`.
  - If count == 0: go to DONE.
  - If count > MAX_WORDS: set `load_error`, go to DONE, no writes.
  - Otherwise go to RECEIVE.
- `start` while `busy` is ignored.
- RECEIVE:
  - `byte_ready` = 1 (registered or combinational from state; no dependency on `byte_valid`).
  - A byte is accepted when `byte_valid` && `byte_ready`: shift register = {shift[23:0], byte_data}, byte index + 1.
  - On acceptance of the 4th byte (byte index 3), go to WRITE.
  - Resulting word: first byte in [31:24], last byte in [7:0].
- WRITE (exactly one cycle):
  - `mem_write_enable` = 1, `mem_write_address` = word index, `mem_write_data` = assembled word.
  - `byte_ready` = 0; `byte_valid` in this cycle is not consumed and the source must hold it.
  - Next edge: if word index == count−1, go to DONE; else word index + 1, byte index 0, go to RECEIVE.
- `mem_write_address` and `mem_write_data` hold their last values outside WRITE. Only `mem_write_enable` qualifies them.
- DONE: `load_done` = 1, `busy` = 0, `byte_ready` = 0. Remains in DONE until `start` or reset.
- Throughput: at most one word per 5 cycles (4 byte acceptances + 1 write cycle).
- Gaps in `byte_valid` stall indefinitely with no timeout; state and partial word are held.
- Word index never exceeds count−1 ≤ MAX_WORDS−1, so no address wrap occurs. The index is zero-extended to ADDRESS_WIDTH.
- `start` and `byte_valid` in the same cycle in IDLE: `start` is taken, the byte is not accepted (`byte_ready` is 0 in IDLE).

Test Plan:
- Reset, start with count=2, bytes 20,08,00,05 then 00,00,00,0C streamed back-to-back (hex values).
  - Writes addr 0 = 32'h20080005, then addr 1 = 32'h0000000C.
  - Each write strobe lasts exactly 1 cycle.
  - `load_done` rises the cycle after the second write.
  - `byte_ready` is low in both WRITE cycles.
- Count=1, `byte_valid` toggled with 3-cycle gaps between bytes AA,BB,CC,DD.
  - Single write of 32'hAABBCCDD at addr 0.
  - No spurious strobe during stalls.
- Count=0 → DONE the next cycle, `mem_write_enable` never asserted, `load_error` = 0. Count=MAX_WORDS+1 → `load_error` = 1, `load_done` = 1, no writes.
- Assert `reset` asynchronously after 2 bytes of the second word of a count=3 load.
  - All outputs are 0 immediately, state IDLE.
  - A fresh start with count=1 writes addr 0, not addr 1.
- Pulse `start` repeatedly while busy → ignored; the original count is honoured. `start` in DONE with count=1 → `load_done` clears and a new load runs to completion.
- Count=MAX_WORDS with a random byte stream → exactly MAX_WORDS writes at addresses 0..MAX_WORDS−1, all data matching the scoreboard.

Source files
------------

// File: rtl/instruction_loader.sv
// Byte-stream loader for the instruction memory: packs 4 bytes (MSB first) into
// a 32-bit word and writes consecutive word addresses from 0 up to count-1.
module instruction_loader #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int MAX_WORDS     = 64,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [COUNT_WIDTH-1:0]   instruction_count,
    input  logic [7:0]               byte_data,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic                     mem_write_enable,
    output logic [ADDRESS_WIDTH-1:0] mem_write_address,
    output logic [31:0]              mem_write_data,
    output logic                     busy,
    output logic                     load_done,
    output logic                     load_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                   state_reg;
    logic [COUNT_WIDTH-1:0]   count_reg;
    logic [COUNT_WIDTH-1:0]   word_index_reg;
    logic [1:0]               byte_index_reg;
    logic [31:0]              shift_reg;
    logic [31:0]              shift_next;
    logic [31:0]              write_data_reg;
    logic [ADDRESS_WIDTH-1:0] write_address_reg;
    logic                     error_reg;

    assign shift_next = {shift_reg[23:0], byte_data};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            count_reg         <= '0;
            word_index_reg    <= '0;
            byte_index_reg    <= '0;
            shift_reg         <= '0;
            write_data_reg    <= '0;
            write_address_reg <= '0;
            error_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        count_reg      <= instruction_count;
                        word_index_reg <= '0;
                        byte_index_reg <= '0;
                        error_reg      <= 1'b0;
                        if (instruction_count == '0) begin
                            state_reg <= DONE;
                        end else if (instruction_count > COUNT_WIDTH'(MAX_WORDS)) begin
                            error_reg <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= RECEIVE;
                        end
                    end
                end
                RECEIVE: begin
                    if (byte_valid) begin
                        shift_reg      <= shift_next;
                        byte_index_reg <= byte_index_reg + 2'd1;
                        // Capture the finished word so address/data hold after the strobe.
                        if (byte_index_reg == 2'd3) begin
                            write_data_reg    <= shift_next;
                            write_address_reg <= ADDRESS_WIDTH'(word_index_reg);
                            state_reg         <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (word_index_reg == count_reg - COUNT_WIDTH'(1)) begin
                        state_reg <= DONE;
                    end else begin
                        word_index_reg <= word_index_reg + COUNT_WIDTH'(1);
                        byte_index_reg <= '0;
                        state_reg      <= RECEIVE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign byte_ready        = (state_reg == RECEIVE);
    assign mem_write_enable  = (state_reg == WRITE);
    assign busy              = (state_reg == RECEIVE) || (state_reg == WRITE);
    assign load_done         = (state_reg == DONE);
    assign load_error        = error_reg;
    assign mem_write_address = write_address_reg;
    assign mem_write_data    = write_data_reg;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: streams bytes, records memory writes,
// and checks them against hand-computed words.
module tb_instruction_loader;

    localparam int ADDRESS_WIDTH = 32;
    localparam int MAX_WORDS     = 64;
    localparam int COUNT_WIDTH   = 8;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     start;
    logic [COUNT_WIDTH-1:0]   instruction_count;
    logic [7:0]               byte_data;
    logic                     byte_valid;
    logic                     byte_ready;
    logic                     mem_write_enable;
    logic [ADDRESS_WIDTH-1:0] mem_write_address;
    logic [31:0]              mem_write_data;
    logic                     busy;
    logic                     load_done;
    logic                     load_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr [256];
    logic [31:0] wr_data [256];
    int          wr_count = 0;
    logic        prev_we  = 1'b0;

    logic [31:0] exp_word [MAX_WORDS];
    int          base;

    instruction_loader #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .MAX_WORDS     (MAX_WORDS),
        .COUNT_WIDTH   (COUNT_WIDTH)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .instruction_count (instruction_count),
        .byte_data         (byte_data),
        .byte_valid        (byte_valid),
        .byte_ready        (byte_ready),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .busy              (busy),
        .load_done         (load_done),
        .load_error        (load_error)
    );

    always #5 clock = ~clock;

    // Write monitor: samples 1 time unit after each rising edge.
    always @(posedge clock) begin
        #1;
        if (prev_we) begin
            checks++;
            assert (mem_write_enable === 1'b0) else begin
                errors++;
                $error("FAIL strobe_width: observed %b expected 0", mem_write_enable);
            end
        end
        if (mem_write_enable === 1'b1) begin
            checks++;
            assert (byte_ready === 1'b0) else begin
                errors++;
                $error("FAIL ready_in_write: observed %b expected 0", byte_ready);
            end
            if (wr_count < 256) begin
                wr_addr[wr_count] = mem_write_address;
                wr_data[wr_count] = mem_write_data;
            end
            wr_count++;
            $display("write addr=%0d data=%h", mem_write_address, mem_write_data);
        end
        prev_we = (mem_write_enable === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 50) begin
            errors++;
            $display("FAIL send_timeout: observed no byte_ready expected byte_ready within 50 cycles");
        end
        @(negedge clock);
        byte_valid = 1'b0;
    endtask

    task automatic start_load(input logic [COUNT_WIDTH-1:0] cnt);
        start             = 1'b1;
        instruction_count = cnt;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; instruction_count = '0;
        byte_valid = 1'b0; byte_data = '0;
        repeat (2) @(negedge clock);
        chk("rst_ready", byte_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_error", load_error, 0);
        chk("rst_we", mem_write_enable, 0);
        chk("rst_addr", mem_write_address, 0);
        chk("rst_data", mem_write_data, 0);
        reset = 1'b0;
        @(negedge clock);

        // Back-to-back two-word load; a byte offered alongside start must be ignored.
        base = wr_count;
        start = 1'b1; instruction_count = 8'd2; byte_valid = 1'b1; byte_data = 8'hFF;
        @(negedge clock);
        start = 1'b0; byte_valid = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_ready", byte_ready, 1);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
        chk("t1_done_in_write", load_done, 0);
        @(negedge clock);
        chk("t1_done", load_done, 1);
        chk("t1_busy_done", busy, 0);
        chk("t1_ready_done", byte_ready, 0);
        chk("t1_nwrites", wr_count - base, 2);
        chk("t1_addr0", wr_addr[base], 0);
        chk("t1_data0", wr_data[base], 32'h20080005);
        chk("t1_addr1", wr_addr[base+1], 1);
        chk("t1_data1", wr_data[base+1], 32'h0000000C);

        // Single word with 3-cycle gaps between bytes.
        base = wr_count;
        start_load(8'd1);
        send_byte(8'hAA); repeat (3) @(negedge clock);
        chk("t2_stall_ready", byte_ready, 1);
        chk("t2_stall_busy", busy, 1);
        send_byte(8'hBB); repeat (3) @(negedge clock);
        send_byte(8'hCC); repeat (3) @(negedge clock);
        chk("t2_stall_nowrite", wr_count - base, 0);
        send_byte(8'hDD);
        @(negedge clock);
        chk("t2_done", load_done, 1);
        chk("t2_nwrites", wr_count - base, 1);
        chk("t2_addr", wr_addr[base], 0);
        chk("t2_data", wr_data[base], 32'hAABBCCDD);

        // Zero count and oversize count.
        base = wr_count;
        start_load(8'd0);
        chk("t3_zero_done", load_done, 1);
        chk("t3_zero_error", load_error, 0);
        repeat (3) @(negedge clock);
        chk("t3_zero_nowrite", wr_count - base, 0);
        start_load(8'(MAX_WORDS + 1));
        chk("t3_big_done", load_done, 1);
        chk("t3_big_error", load_error, 1);
        repeat (3) @(negedge clock);
        chk("t3_big_nowrite", wr_count - base, 0);
        chk("t3_addr_hold", mem_write_address, 0);
        chk("t3_data_hold", mem_write_data, 32'hAABBCCDD);

        // Asynchronous reset mid-way through the second word.
        base = wr_count;
        start_load(8'd3);
        chk("t4_error_cleared", load_error, 0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        #2 reset = 1'b1;
        #1;
        chk("t4_rst_ready", byte_ready, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_done", load_done, 0);
        chk("t4_rst_we", mem_write_enable, 0);
        chk("t4_rst_addr", mem_write_address, 0);
        chk("t4_rst_data", mem_write_data, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        start_load(8'd1);
        send_byte(8'h77); send_byte(8'h88); send_byte(8'h99); send_byte(8'hAA);
        @(negedge clock);
        chk("t4_done", load_done, 1);
        chk("t4_nwrites", wr_count - base, 2);
        chk("t4_addr", wr_addr[base+1], 0);
        chk("t4_data", wr_data[base+1], 32'h778899AA);

        // start while busy is ignored; start from DONE begins a new load.
        base = wr_count;
        start_load(8'd2);
        send_byte(8'h01); send_byte(8'h02);
        start_load(8'd5);
        send_byte(8'h03);
        start_load(8'd5);
        send_byte(8'h04);
        start_load(8'd5);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        @(negedge clock);
        chk("t5_done", load_done, 1);
        chk("t5_nwrites", wr_count - base, 2);
        chk("t5_data0", wr_data[base], 32'h01020304);
        chk("t5_data1", wr_data[base+1], 32'h05060708);
        repeat (3) @(negedge clock);
        chk("t5_no_extra", wr_count - base, 2);
        start_load(8'd1);
        chk("t5_restart_done", load_done, 0);
        chk("t5_restart_busy", busy, 1);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        @(negedge clock);
        chk("t5_restart_fin", load_done, 1);
        chk("t5_restart_addr", wr_addr[base+2], 0);
        chk("t5_restart_data", wr_data[base+2], 32'hDEADBEEF);

        // Full-capacity load with random bytes.
        base = wr_count;
        start_load(8'(MAX_WORDS));
        for (int w = 0; w < MAX_WORDS; w++) begin
            logic [31:0] word;
            word = $urandom;
            exp_word[w] = word;
            send_byte(word[31:24]); send_byte(word[23:16]);
            send_byte(word[15:8]);  send_byte(word[7:0]);
        end
        @(negedge clock);
        chk("t6_done", load_done, 1);
        chk("t6_nwrites", wr_count - base, MAX_WORDS);
        for (int w = 0; w < MAX_WORDS; w++) begin
            chk($sformatf("t6_addr%0d", w), wr_addr[base+w], w);
            chk($sformatf("t6_data%0d", w), wr_data[base+w], exp_word[w]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
